// File: rtl/dmem_port_scheduler.sv
// Schedules two MEM-stage slots onto one falling-edge single-port data RAM.
// Optional feature: define DMEM_READ_MERGE_EN to merge same-address read pairs.
module dmem_port_scheduler #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd1_en,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              rd2_en,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              mem_stall,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   req2_addr;
  logic [DATA_W-1:0]   req2_wdata;
  logic                req2_wr;
  logic [DATA_W-1:0]   hold1;
  logic [ADDR_W-1:0]   last_addr;
  logic                act1, act2, merge, conflict;

  // Slot activity and conflict detection (both-active pairs split over two cycles)
  always_comb begin
    act1 = rd1_en | wr1_en;
    act2 = rd2_en | wr2_en;
`ifdef DMEM_READ_MERGE_EN
    merge = rd1_en & ~wr1_en & rd2_en & ~wr2_en & (addr1 == addr2);
`else
    merge = 1'b0;
`endif
    conflict = (state == IDLE) & act1 & act2 & ~merge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and RAM/pipeline drive
  always_comb begin
    state_nxt = state;
    ram_addr  = last_addr;
    ram_wdata = wdata1;
    ram_wren  = 1'b0;
    mem_stall = 1'b0;
    rdata1    = ram_q;
    rdata2    = ram_q;
    case (state)
      IDLE: begin
        if (act1) begin
          ram_addr  = addr1;
          ram_wdata = wdata1;
          ram_wren  = wr1_en;
        end else if (act2) begin
          ram_addr  = addr2;
          ram_wdata = wdata2;
          ram_wren  = wr2_en;
        end
        if (conflict) begin
          mem_stall = 1'b1;
          state_nxt = SECOND;
        end
      end
      SECOND: begin
        ram_addr  = req2_addr;
        ram_wdata = req2_wdata;
        ram_wren  = req2_wr;
        rdata1    = hold1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must block a pending slot-2 write immediately, not at the next edge
    if (rst) begin
      ram_wren  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // Deferred slot-2 request, slot-1 load capture, address hold and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req2_addr    <= '0;
      req2_wdata   <= '0;
      req2_wr      <= 1'b0;
      hold1        <= '0;
      last_addr    <= '0;
      conflict_cnt <= '0;
    end else begin
      last_addr <= ram_addr;
      if (conflict) begin
        hold1      <= ram_q;
        req2_addr  <= addr2;
        req2_wdata <= wdata2;
        req2_wr    <= wr2_en;
      end
      if (mem_stall && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Bench for dmem_port_scheduler: directed vector table, reset/saturation sequences,
// and random transactions against a transaction-level program-order memory model.
module tb_dmem_port_scheduler;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
`ifdef DMEM_READ_MERGE_EN
  localparam bit MG = 1'b1;
`else
  localparam bit MG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd1_en = 1'b0, wr1_en = 1'b0, rd2_en = 1'b0, wr2_en = 1'b0;
  logic [ADDR_W-1:0] addr1 = '0, addr2 = '0;
  logic [DATA_W-1:0] wdata1 = '0, wdata2 = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q, rdata1, rdata2;
  logic              ram_wren, mem_stall;
  logic [CNT_W-1:0]  conflict_cnt;
  logic [ADDR_W-1:0] sat_addr;
  logic [DATA_W-1:0] sat_wdata, sat_r1, sat_r2;
  logic              sat_wren, sat_stall;
  logic [3:0]        cnt4;

  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  int total = 0;
  int bad   = 0;
  int stalls = 0;
  logic [ADDR_W-1:0] last_a = '0;
  bit last_valid = 1'b0;

  typedef struct {
    logic rd1, wr1; logic [ADDR_W-1:0] a1; logic [DATA_W-1:0] d1;
    logic rd2, wr2; logic [ADDR_W-1:0] a2; logic [DATA_W-1:0] d2;
    logic exp_stall, exp_wren;
    logic chk1; logic [DATA_W-1:0] exp1;
    logic chk2; logic [DATA_W-1:0] exp2;
    int   exp_cnt;
  } vec_t;

  always #5 clk = ~clk;

  dmem_port_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rd1_en(rd1_en), .wr1_en(wr1_en), .addr1(addr1), .wdata1(wdata1),
    .rd2_en(rd2_en), .wr2_en(wr2_en), .addr2(addr2), .wdata2(wdata2),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .rdata1(rdata1), .rdata2(rdata2), .mem_stall(mem_stall), .conflict_cnt(conflict_cnt)
  );

  dmem_port_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .rd1_en(rd1_en), .wr1_en(wr1_en), .addr1(addr1), .wdata1(wdata1),
    .rd2_en(rd2_en), .wr2_en(wr2_en), .addr2(addr2), .wdata2(wdata2),
    .ram_addr(sat_addr), .ram_wdata(sat_wdata), .ram_wren(sat_wren), .ram_q(ram_q),
    .rdata1(sat_r1), .rdata2(sat_r2), .mem_stall(sat_stall), .conflict_cnt(cnt4)
  );

  // Falling-edge single-port RAM, read-first
  always @(negedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    rd1_en = 0; wr1_en = 0; rd2_en = 0; wr2_en = 0;
  endtask

  task automatic drive(input vec_t v);
    rd1_en = v.rd1; wr1_en = v.wr1; addr1 = v.a1; wdata1 = v.d1;
    rd2_en = v.rd2; wr2_en = v.wr2; addr2 = v.a2; wdata2 = v.d2;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 set_idle(); rst = 1;
    @(posedge clk); #1 rst = 0;
    stalls = 0; last_valid = 0;
  endtask

  // Program-order model: slot 1 acts on memory first, slot 2 sees its effect
  task automatic model(inout vec_t v);
    bit a1, a2, l1, l2, merged;
    a1 = v.rd1 | v.wr1;  a2 = v.rd2 | v.wr2;
    l1 = v.rd1 & ~v.wr1; l2 = v.rd2 & ~v.wr2;
    merged = MG && l1 && l2 && (v.a1 == v.a2);
    v.exp_stall = a1 && a2 && !merged;
    v.exp_wren  = a1 ? v.wr1 : (a2 ? v.wr2 : 1'b0);
    v.chk1 = l1; v.chk2 = l2; v.exp1 = '0; v.exp2 = '0;
    if (a1) begin v.exp1 = ref_mem[v.a1]; if (v.wr1) ref_mem[v.a1] = v.d1; end
    if (a2) begin v.exp2 = ref_mem[v.a2]; if (v.wr2) ref_mem[v.a2] = v.d2; end
    if (v.exp_stall) stalls++;
    v.exp_cnt = stalls;
  endtask

  // One transaction, its optional SECOND cycle, then one idle cycle
  task automatic do_txn(input vec_t v, input string tag);
    int sat;
    @(posedge clk); #1 drive(v);
    @(negedge clk); #1;
    chk({tag, ".stall0"}, 64'(mem_stall), 64'(v.exp_stall));
    chk({tag, ".wren0"}, 64'(ram_wren), 64'(v.exp_wren));
    if (v.exp_stall) begin
      @(posedge clk); #1;
      rd1_en = 1'($urandom); wr1_en = 1'($urandom); addr1 = ADDR_W'($urandom);
      rd2_en = 1'($urandom); wr2_en = 1'($urandom); addr2 = ADDR_W'($urandom);
      wdata1 = $urandom; wdata2 = $urandom;
      @(negedge clk); #1;
      chk({tag, ".stall1"}, 64'(mem_stall), 64'd0);
      chk({tag, ".wren1"}, 64'(ram_wren), 64'(v.wr2));
      chk({tag, ".addr1"}, 64'(ram_addr), 64'(v.a2));
    end
    if (v.chk1) chk({tag, ".rdata1"}, 64'(rdata1), 64'(v.exp1));
    if (v.chk2) chk({tag, ".rdata2"}, 64'(rdata2), 64'(v.exp2));
    if (v.exp_stall || (!(v.rd1 | v.wr1) && (v.rd2 | v.wr2))) begin
      last_a = v.a2; last_valid = 1;
    end else if (v.rd1 | v.wr1) begin
      last_a = v.a1; last_valid = 1;
    end
    @(posedge clk); #1 set_idle();
    @(negedge clk); #1;
    chk({tag, ".idle_wren"}, 64'(ram_wren), 64'd0);
    chk({tag, ".idle_stall"}, 64'(mem_stall), 64'd0);
    if (last_valid) chk({tag, ".idle_addr"}, 64'(ram_addr), 64'(last_a));
    sat = (v.exp_cnt > 15) ? 15 : v.exp_cnt;
    chk({tag, ".cnt"}, 64'(conflict_cnt), 64'(v.exp_cnt));
    chk({tag, ".cnt4"}, 64'(cnt4), 64'(sat));
  endtask

  vec_t tbl [10];

  initial begin
    vec_t v;
    for (int i = 0; i < (1 << ADDR_W); i++) begin mem[i] = '0; ref_mem[i] = '0; end

    //          rd1 wr1 a1 d1            rd2 wr2 a2 d2    stall wren chk1 exp1          chk2 exp2          cnt
    tbl[0] = '{0, 1, 5, 32'hA5A5A5A5,  0, 0, 0, 0,      0,   1,   0, 0,             0, 0,             0};
    tbl[1] = '{1, 0, 5, 0,             0, 0, 0, 0,      0,   0,   1, 32'hA5A5A5A5,  0, 0,             0};
    tbl[2] = '{0, 1, 3, 32'h11,        1, 0, 3, 0,      1,   1,   0, 0,             1, 32'h11,        1};
    tbl[3] = '{0, 1, 7, 32'h22,        0, 1, 7, 32'h33, 1,   1,   0, 0,             0, 0,             2};
    tbl[4] = '{1, 0, 7, 0,             0, 0, 0, 0,      0,   0,   1, 32'h33,        0, 0,             2};
    tbl[5] = '{0, 0, 0, 0,             0, 1, 9, 32'h44, 0,   1,   0, 0,             0, 0,             2};
    tbl[6] = '{1, 0, 9, 0,             1, 0, 9, 0,      !MG, 0,   1, 32'h44,        1, 32'h44,        3 - int'(MG)};
    tbl[7] = '{1, 0, 3, 0,             1, 0, 5, 0,      1,   0,   1, 32'h11,        1, 32'hA5A5A5A5,  4 - int'(MG)};
    tbl[8] = '{1, 1, 4, 32'h77,        1, 0, 4, 0,      1,   1,   0, 0,             1, 32'h77,        5 - int'(MG)};
    tbl[9] = '{0, 0, 0, 0,             0, 0, 0, 0,      0,   0,   0, 0,             0, 0,             5 - int'(MG)};

    // Reset holds stall and write low even with a conflicting pair applied
    rst = 1;
    rd1_en = 0; wr1_en = 1; addr1 = 1; wdata1 = 32'hDEAD; rd2_en = 1; addr2 = 1;
    #2;
    chk("rst.stall", 64'(mem_stall), 64'd0);
    chk("rst.wren", 64'(ram_wren), 64'd0);
    chk("rst.cnt", 64'(conflict_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 set_idle(); rst = 0;

    for (int i = 0; i < 10; i++) do_txn(tbl[i], $sformatf("vec%0d", i));
    chk("mem7", 64'(mem[7]), 64'h33);

    // Reset during SECOND abandons the slot-2 store
    pulse_reset();
    @(posedge clk); #1;
    wr1_en = 1; addr1 = 2; wdata1 = 32'h55; wr2_en = 1; addr2 = 2; wdata2 = 32'h66;
    @(negedge clk); #1 chk("r2.stall", 64'(mem_stall), 64'd1);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("r2.wren", 64'(ram_wren), 64'd0);
    chk("r2.stall_rst", 64'(mem_stall), 64'd0);
    @(negedge clk); #1 rst = 0; set_idle();
    @(posedge clk); @(negedge clk); #1;
    chk("r2.mem2", 64'(mem[2]), 64'h55);
    chk("r2.cnt", 64'(conflict_cnt), 64'd0);
    chk("r2.idle_stall", 64'(mem_stall), 64'd0);
    stalls = 0; last_valid = 0;
    v = '{1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0};
    do_txn(v, "r2.read");

    // Counter saturation on the 4-bit instance
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      v = '{0, 1, ADDR_W'(32 + i), $urandom, 0, 1, ADDR_W'(64 + i), $urandom, 1, 1, 0, 0, 0, 0, i + 1};
      do_txn(v, $sformatf("sat%0d", i));
    end
    chk("sat.final4", 64'(cnt4), 64'd15);
    chk("sat.final16", 64'(conflict_cnt), 64'd20);

    // Random transactions over a small address window
    pulse_reset();
    for (int n = 0; n < 300; n++) begin
      v.rd1 = 1'($urandom); v.wr1 = ($urandom_range(0, 2) == 0);
      v.rd2 = 1'($urandom); v.wr2 = ($urandom_range(0, 2) == 0);
      v.a1 = ADDR_W'(16 + $urandom_range(0, 7)); v.d1 = $urandom;
      v.a2 = ($urandom_range(0, 2) == 0) ? v.a1 : ADDR_W'(16 + $urandom_range(0, 7));
      v.d2 = $urandom;
      model(v);
      do_txn(v, $sformatf("rnd%0d", n));
    end
    for (int a = 16; a < 24; a++) chk($sformatf("rmem%0d", a), 64'(mem[a]), 64'(ref_mem[a]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
